cube_face_color_buffer: RTL and testbench

Parametrised storage for the colour state of every face of an N×N magic cube. Each command writes one colour code into a masked set of facelets on one face, or clears the face. The block scans the facelets serially, one per cycle, and finishes each command with a one-cycle `done` pulse. It sits between the colour-classification stage and the cube-solver front end, and provides a registered, packed per-face read port.

---
 rtl/cube_pkg.sv | 38 +++
 rtl/cube_face_bank.sv | 59 +++++
 rtl/cube_face_color_buffer.sv | 151 +++++++++++++++
 tb/tb_cube_face_color_buffer.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/cube_pkg.sv
// Shared types and constants for the cube face colour buffer: colour codes,
// face indices, controller states and the EMPTY marker.
package cube_pkg;

    localparam int COLOR_W = 3;

    typedef enum logic [COLOR_W-1:0] {
        W     = 3'd0,
        Y     = 3'd1,
        R     = 3'd2,
        O     = 3'd3,
        B     = 3'd4,
        G     = 3'd5,
        EMPTY = 3'd7
    } color_e;

    localparam logic [COLOR_W-1:0] EMPTY_CODE = 3'b111;

    // Face indices carry a prefix so they do not collide with the colour literals B and R.
    localparam logic [2:0] FACE_U = 3'd0;
    localparam logic [2:0] FACE_D = 3'd1;
    localparam logic [2:0] FACE_F = 3'd2;
    localparam logic [2:0] FACE_B = 3'd3;
    localparam logic [2:0] FACE_L = 3'd4;
    localparam logic [2:0] FACE_R = 3'd5;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LATCH = 2'd1,
        SCAN  = 2'd2,
        DONE  = 2'd3
    } state_e;

    function automatic logic face_in_range(input logic [2:0] face, input int faces);
        return (32'(face) < faces);
    endfunction

endpackage

// File: rtl/cube_face_bank.sv
// Facelet cell array with one write port and a registered, packed per-face
// read port. Out-of-range read faces return all-EMPTY.
module cube_face_bank
    import cube_pkg::*;
#(
    parameter int GRID  = 3,
    parameter int CW    = 3,
    parameter int FACES = 6,
    parameter int N     = GRID * GRID,
    parameter int IDXW  = (N > 1) ? $clog2(N) : 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              we,
    input  logic [2:0]        wr_face,
    input  logic [IDXW-1:0]   wr_idx,
    input  logic [CW-1:0]     wr_data,
    input  logic [2:0]        rd_face,
    output logic [N*CW-1:0]   face_dout
);

    logic [CW-1:0]   mem [FACES][N];
    logic [N*CW-1:0] face_dout_reg;
    logic [N*CW-1:0] face_dout_next;
    logic            rd_ok;

    // Reset must wipe every cell in a single edge, so the array carries a reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int f = 0; f < FACES; f++) begin
                for (int i = 0; i < N; i++) begin
                    mem[f][i] <= '1;
                end
            end
        end else if (we) begin
            mem[wr_face][wr_idx] <= wr_data;
        end
    end

    assign rd_ok = face_in_range(rd_face, FACES);

    generate
        for (genvar gi = 0; gi < N; gi++) begin : g_rd
            assign face_dout_next[gi*CW +: CW] = rd_ok ? mem[rd_face][gi] : '1;
        end
    endgenerate

    // Read sees the array before this edge's write: same-cell collisions return old data.
    always_ff @(posedge clk) begin
        if (rst) begin
            face_dout_reg <= '1;
        end else begin
            face_dout_reg <= face_dout_next;
        end
    end

    assign face_dout = face_dout_reg;

endmodule

// File: rtl/cube_face_color_buffer.sv
// Command-driven colour store for an N x N cube: serial masked write/clear of
// one face per command. Define CUBE_FACE_COMPLETE_EN to add face_complete.
module cube_face_color_buffer
    import cube_pkg::*;
#(
    parameter int GRID  = 3,
    parameter int CW    = 3,
    parameter int FACES = 6
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   enable,
    input  logic [2:0]             face_sel,
    input  logic [GRID*GRID-1:0]   position_mask,
    input  logic [CW-1:0]          color_coding,
    input  logic                   clear,
    input  logic [2:0]             rd_face,
    output logic [GRID*GRID*CW-1:0] face_dout,
    output logic                   busy,
    output logic                   done,
    output logic                   err
`ifdef CUBE_FACE_COMPLETE_EN
    ,
    output logic [FACES-1:0]       face_complete
`endif
);

    localparam int N    = GRID * GRID;
    localparam int IDXW = (N > 1) ? $clog2(N) : 1;
    localparam logic [IDXW-1:0] LAST_IDX = IDXW'(N - 1);

    state_e          state_reg, state_next;
    logic [IDXW-1:0] idx_reg, idx_next;
    logic [2:0]      face_reg, face_next;
    logic [N-1:0]    mask_reg, mask_next;
    logic [CW-1:0]   color_reg, color_next;
    logic            clear_reg, clear_next;
    logic            err_reg, err_next;
    logic            we;
    logic [CW-1:0]   wr_data;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= IDLE;
            idx_reg   <= '0;
            face_reg  <= '0;
            mask_reg  <= '0;
            color_reg <= '0;
            clear_reg <= 1'b0;
            err_reg   <= 1'b0;
        end else begin
            state_reg <= state_next;
            idx_reg   <= idx_next;
            face_reg  <= face_next;
            mask_reg  <= mask_next;
            color_reg <= color_next;
            clear_reg <= clear_next;
            err_reg   <= err_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        idx_next   = idx_reg;
        face_next  = face_reg;
        mask_next  = mask_reg;
        color_next = color_reg;
        clear_next = clear_reg;
        err_next   = err_reg;
        we         = 1'b0;
        case (state_reg)
            IDLE: begin
                if (enable) begin
                    face_next  = face_sel;
                    mask_next  = position_mask;
                    color_next = color_coding;
                    clear_next = clear;
                    state_next = LATCH;
                end
            end
            LATCH: begin
                idx_next = '0;
                if (!face_in_range(face_reg, FACES)) begin
                    err_next   = 1'b1;
                    state_next = DONE;
                end else begin
                    err_next   = 1'b0;
                    state_next = SCAN;
                end
            end
            SCAN: begin
                we       = clear_reg | mask_reg[idx_reg];
                idx_next = idx_reg + IDXW'(1);
                if (idx_reg == LAST_IDX) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    assign wr_data = clear_reg ? '1 : color_reg;
    assign busy    = (state_reg != IDLE);
    assign done    = (state_reg == DONE);
    assign err     = done & err_reg;

    cube_face_bank #(
        .GRID  (GRID),
        .CW    (CW),
        .FACES (FACES)
    ) u_bank (
        .clk       (clk),
        .rst       (rst),
        .we        (we),
        .wr_face   (face_reg),
        .wr_idx    (idx_reg),
        .wr_data   (wr_data),
        .rd_face   (rd_face),
        .face_dout (face_dout)
    );

`ifdef CUBE_FACE_COMPLETE_EN
    // A clear write drops the facelet's written bit; any colour write sets it.
    generate
        for (genvar gi = 0; gi < FACES; gi++) begin : g_face
            logic [N-1:0] written_reg;
            logic         complete_reg;

            always_ff @(posedge clk) begin
                if (rst) begin
                    written_reg  <= '0;
                    complete_reg <= 1'b0;
                end else begin
                    if (we && (face_reg == 3'(gi))) begin
                        written_reg[idx_reg] <= ~clear_reg;
                    end
                    complete_reg <= &written_reg;
                end
            end

            assign face_complete[gi] = complete_reg;
        end
    endgenerate
`endif

endmodule

// File: tb/tb_cube_face_color_buffer.sv
// Directed, table-driven bench for cube_face_color_buffer (GRID=3, CW=3, FACES=6)
// with hand sequences for mid-scan enable, reset abort and face_complete.
module tb_cube_face_color_buffer;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        enable = 1'b0;
    logic [2:0]  face_sel = '0;
    logic [8:0]  position_mask = '0;
    logic [2:0]  color_coding = '0;
    logic        clear = 1'b0;
    logic [2:0]  rd_face = '0;
    logic [26:0] face_dout;
    logic        busy;
    logic        done;
    logic        err;
`ifdef CUBE_FACE_COMPLETE_EN
    logic [5:0]  face_complete;
`endif

    int checks = 0;
    int errors = 0;

    logic [2:0] mdl [6][9];

    typedef struct {
        logic [2:0]  face;
        logic [8:0]  mask;
        logic [2:0]  col;
        logic        clr;
        int          exp_lat;
        logic        exp_err;
        logic [26:0] exp_dout;
    } vec_t;

    vec_t vecs [9];

    always #5 clk = ~clk;

    cube_face_color_buffer #(
        .GRID  (3),
        .CW    (3),
        .FACES (6)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .enable        (enable),
        .face_sel      (face_sel),
        .position_mask (position_mask),
        .color_coding  (color_coding),
        .clear         (clear),
        .rd_face       (rd_face),
        .face_dout     (face_dout),
        .busy          (busy),
        .done          (done),
        .err           (err)
`ifdef CUBE_FACE_COMPLETE_EN
        ,
        .face_complete (face_complete)
`endif
    );

    initial begin
        #1000000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1);
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    function automatic logic [26:0] model_face(input int f);
        logic [26:0] v;
        v = '1;
        if (f < 6) begin
            for (int i = 0; i < 9; i++) v[i*3 +: 3] = mdl[f][i];
        end
        return v;
    endfunction

    task automatic model_apply(input logic [2:0] f, input logic [8:0] m, input logic [2:0] col, input logic clr);
        if (f < 3'd6) begin
            for (int i = 0; i < 9; i++) begin
                if (clr) mdl[f][i] = 3'b111;
                else if (m[i]) mdl[f][i] = col;
            end
        end
    endtask

    task automatic model_reset();
        for (int f = 0; f < 6; f++)
            for (int i = 0; i < 9; i++) mdl[f][i] = 3'b111;
    endtask

    task automatic read_face(input logic [2:0] f, output logic [26:0] d);
        @(negedge clk);
        rd_face = f;
        @(negedge clk);
        d = face_dout;
    endtask

    task automatic check_all_faces(input string tag);
        logic [26:0] d;
        for (int f = 0; f < 6; f++) begin
            read_face(3'(f), d);
            chk($sformatf("%s_face%0d", tag, f), 64'(d), 64'(model_face(f)));
        end
    endtask

    // Issues one command, then watches 30 cycles; c counts negedges after the acceptance edge.
    task automatic run_cmd(input logic [2:0] f, input logic [8:0] m, input logic [2:0] col,
                           input logic clr, input int mid_at,
                           output int lat, output logic e, output int dcnt, output int bfall);
        lat = -1; e = 1'b0; dcnt = 0; bfall = -1;
        @(negedge clk);
        enable = 1'b1; face_sel = f; position_mask = m; color_coding = col; clear = clr;
        @(negedge clk);
        enable = 1'b0; face_sel = ~f; position_mask = ~m; color_coding = ~col; clear = ~clr;
        for (int c = 0; c < 30; c++) begin
            if (c > 0) @(negedge clk);
            if (done) begin
                if (lat < 0) begin
                    lat = c;
                    e = err;
                end
                dcnt++;
            end
            if (!busy && bfall < 0) bfall = c;
            if (c == mid_at) begin
                enable = 1'b1; face_sel = f; position_mask = 9'h1FF; color_coding = 3'b100; clear = 1'b0;
            end else begin
                enable = 1'b0;
            end
        end
        enable = 1'b0;
    endtask

    initial begin
        int          lat, dcnt, bfall;
        logic        e;
        logic [26:0] d;

        vecs[0] = '{3'd2, 9'h011, 3'b010, 1'b0, 10, 1'b0, 27'h7FFAFFA};
        vecs[1] = '{3'd7, 9'h1FF, 3'b000, 1'b0,  1, 1'b1, 27'h7FFFFFF};
        vecs[2] = '{3'd6, 9'h1FF, 3'b001, 1'b0,  1, 1'b1, 27'h7FFFFFF};
        vecs[3] = '{3'd0, 9'h000, 3'b000, 1'b0, 10, 1'b0, 27'h7FFFFFF};
        vecs[4] = '{3'd0, 9'h1FF, 3'b000, 1'b0, 10, 1'b0, 27'h0000000};
        vecs[5] = '{3'd2, 9'h100, 3'b101, 1'b0, 10, 1'b0, 27'h5FFAFFA};
        vecs[6] = '{3'd0, 9'h000, 3'b000, 1'b1, 10, 1'b0, 27'h7FFFFFF};
        vecs[7] = '{3'd5, 9'h1FF, 3'b110, 1'b0, 10, 1'b0, 27'h6DB6DB6};
        vecs[8] = '{3'd5, 9'h0F0, 3'b000, 1'b1, 10, 1'b0, 27'h7FFFFFF};

        model_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        chk("reset_busy", 64'(busy), 64'(0));
        chk("reset_done", 64'(done), 64'(0));
        chk("reset_err", 64'(err), 64'(0));
        chk("reset_dout", 64'(face_dout), 64'(27'h7FFFFFF));
        rst = 1'b0;
        check_all_faces("reset");
`ifdef CUBE_FACE_COMPLETE_EN
        chk("reset_complete", 64'(face_complete), 64'(0));
`endif

        for (int v = 0; v < 9; v++) begin
            run_cmd(vecs[v].face, vecs[v].mask, vecs[v].col, vecs[v].clr, -1, lat, e, dcnt, bfall);
            model_apply(vecs[v].face, vecs[v].mask, vecs[v].col, vecs[v].clr);
            $display("cmd %0d face=%0d mask=%03h col=%0d clr=%0d lat=%0d err=%0d dones=%0d busy_fall=%0d",
                     v, vecs[v].face, vecs[v].mask, vecs[v].col, vecs[v].clr, lat, e, dcnt, bfall);
            chk($sformatf("v%0d_lat", v), 64'(lat), 64'(vecs[v].exp_lat));
            chk($sformatf("v%0d_err", v), 64'(e), 64'(vecs[v].exp_err));
            chk($sformatf("v%0d_done_count", v), 64'(dcnt), 64'(1));
            chk($sformatf("v%0d_busy_fall", v), 64'(bfall), 64'(vecs[v].exp_lat + 1));
            read_face(vecs[v].face, d);
            chk($sformatf("v%0d_dout", v), 64'(d), 64'(vecs[v].exp_dout));
            check_all_faces($sformatf("v%0d", v));
        end

        // Second enable during the scan must be dropped, not queued.
        run_cmd(3'd1, 9'h003, 3'b001, 1'b0, 4, lat, e, dcnt, bfall);
        model_apply(3'd1, 9'h003, 3'b001, 1'b0);
        $display("cmd midscan face=1 lat=%0d err=%0d dones=%0d busy_fall=%0d", lat, e, dcnt, bfall);
        chk("mid_lat", 64'(lat), 64'(10));
        chk("mid_done_count", 64'(dcnt), 64'(1));
        read_face(3'd1, d);
        chk("mid_dout", 64'(d), 64'(27'h7FFFFC9));
        check_all_faces("mid");

        // Reset mid-scan; the read at c=5 also shows old-data on a same-cell collision.
        dcnt = 0;
        @(negedge clk);
        rd_face = 3'd3; enable = 1'b1; face_sel = 3'd3; position_mask = 9'h1FF;
        color_coding = 3'b011; clear = 1'b0;
        @(negedge clk);
        enable = 1'b0;
        repeat (5) begin
            @(negedge clk);
            if (done) dcnt++;
        end
        chk("abort_partial_read", 64'(face_dout), 64'(27'h7FFFEDB));
        rst = 1'b1;
        @(negedge clk);
        chk("abort_busy", 64'(busy), 64'(0));
        chk("abort_done", 64'(done), 64'(0));
        rst = 1'b0;
        repeat (15) begin
            @(negedge clk);
            if (done) dcnt++;
        end
        $display("cmd abort face=3 dones=%0d", dcnt);
        chk("abort_done_count", 64'(dcnt), 64'(0));
        model_reset();
        check_all_faces("abort");

`ifdef CUBE_FACE_COMPLETE_EN
        run_cmd(3'd4, 9'h1FF, 3'b001, 1'b0, -1, lat, e, dcnt, bfall);
        model_apply(3'd4, 9'h1FF, 3'b001, 1'b0);
        $display("cmd complete_fill face=4 lat=%0d complete=%02h", lat, face_complete);
        chk("complete_set", 64'(face_complete), 64'(6'b010000));
        run_cmd(3'd4, 9'h000, 3'b000, 1'b1, -1, lat, e, dcnt, bfall);
        model_apply(3'd4, 9'h000, 3'b000, 1'b1);
        $display("cmd complete_clear face=4 lat=%0d complete=%02h", lat, face_complete);
        chk("complete_cleared", 64'(face_complete), 64'(0));
        check_all_faces("complete");
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
